// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - fetch sequencer memory, redirect and decode-side signal bundle
interface fetch_sequencer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          start;
    logic [31:0]   fetch_addr;
    logic [31:0]   mem_ins;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_ins;
    logic [31:0]   out_pc;
    logic [CW-1:0] count;
    logic          busy;

    modport master (
        output start, mem_ins, redirect, redirect_pc, out_ready,
        input  fetch_addr, out_valid, out_ins, out_pc, count, busy
    );

    modport slave (
        input  start, mem_ins, redirect, redirect_pc, out_ready,
        output fetch_addr, out_valid, out_ins, out_pc, count, busy
    );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch controller with prefetch FIFO and redirect flush
module fetch_sequencer #(
    parameter int RESET_PC  = 0,
    parameter int MEM_WORDS = 100,
    parameter int DEPTH     = 4
) (
    input  logic             clk,
    input  logic             rst,
    fetch_sequencer_if.slave bus
);
    localparam int          AW        = $clog2(DEPTH);
    localparam int          CW        = AW + 1;
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);
    localparam logic [31:0] PC_INIT   = 32'(RESET_PC);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

    state_t        r_state, w_state_next;
    logic [31:0]   r_pc, w_pc_next;
    logic [31:0]   r_ins_mem [DEPTH];
    logic [31:0]   r_pc_mem  [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [CW-1:0] r_count;
    logic          w_push, w_pop, w_valid;

    always_comb begin
        w_valid = (r_count != '0);
        // A pop in the same cycle never frees room for a push: fullness is judged on registered count.
        w_push  = (r_state == S_FETCH) && (r_pc < MEM_LIMIT) &&
                  (r_count != CW'(DEPTH)) && !bus.redirect;
        w_pop   = w_valid && bus.out_ready;
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        case (r_state)
            S_IDLE: begin
                if (bus.redirect) w_pc_next = bus.redirect_pc;
                if (bus.start)    w_state_next = S_FETCH;
            end
            S_FETCH: begin
                if (bus.redirect)  w_pc_next = bus.redirect_pc;
                else if (w_push)   w_pc_next = r_pc + 32'd1;
                if (w_pc_next >= MEM_LIMIT) w_state_next = S_DONE;
            end
            S_DONE: begin
                if (bus.redirect) begin
                    w_pc_next = bus.redirect_pc;
                    if (bus.redirect_pc < MEM_LIMIT) w_state_next = S_FETCH;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= PC_INIT;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (bus.redirect && (r_state != S_IDLE)) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage needs no reset; outputs are gated by count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ins_mem[r_wr] <= bus.mem_ins;
            r_pc_mem[r_wr]  <= r_pc;
        end
    end

    assign bus.fetch_addr = r_pc;
    assign bus.out_valid  = w_valid;
    assign bus.out_ins    = w_valid ? r_ins_mem[r_rd] : 32'd0;
    assign bus.out_pc     = w_valid ? r_pc_mem[r_rd]  : 32'd0;
    assign bus.count      = r_count;
    assign bus.busy       = (r_state == S_FETCH) || w_valid;
endmodule
